// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the programmable synchronous FIFO.
package fifo_pkg;

   localparam int STATUS_CNT_W = 16;

   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   typedef struct packed {
      logic                    full;
      logic                    empty;
      logic                    almostfull;
      logic                    almostempty;
      logic [STATUS_CNT_W-1:0] count;
   } fifo_status_t;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, synchronous registered read.
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [WIDTH-1:0] rdata_r;

   // storage write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   // registered read port; returns pre-write contents on an address collision
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_r <= {WIDTH{1'b0}};
      end else if (re) begin
         rdata_r <= mem_r[raddr];
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable almost-flags, occupancy count,
// optional first-word-fall-through read and sticky error status.
module sync_fifo_prog
   import fifo_pkg::*;
#(
   parameter int FIFO_WIDTH = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int FWFT       = 0,
   parameter int AF_LEVEL   = FIFO_DEPTH - 1,
   parameter int AE_LEVEL   = 1,
   localparam int CW        = count_width(FIFO_DEPTH),
   localparam int PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [FIFO_WIDTH-1:0] data_in,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic                  clr_err,
   output logic [FIFO_WIDTH-1:0] data_out,
   output logic                  valid,
   output logic                  wr_ack,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  full,
   output logic                  empty,
   output logic                  almostfull,
   output logic                  almostempty,
   output logic [CW-1:0]         count,
   output logic                  sticky_err
);

   if (FIFO_DEPTH < 2) begin : g_bad_depth
      $error("sync_fifo_prog: FIFO_DEPTH must be >= 2");
   end
   if ((AF_LEVEL < 1) || (AF_LEVEL > FIFO_DEPTH - 1)) begin : g_bad_af
      $error("sync_fifo_prog: AF_LEVEL must be in 1..FIFO_DEPTH-1");
   end
   if ((AE_LEVEL < 1) || (AE_LEVEL > FIFO_DEPTH - 1)) begin : g_bad_ae
      $error("sync_fifo_prog: AE_LEVEL must be in 1..FIFO_DEPTH-1");
   end
   if (CW > STATUS_CNT_W) begin : g_bad_cw
      $error("sync_fifo_prog: FIFO_DEPTH too large for status count field");
   end

   logic [PW-1:0]         wr_ptr_r;
   logic [PW-1:0]         rd_ptr_r;
   logic [PW-1:0]         rd_ptr_nxt_s;
   logic [CW-1:0]         count_r;
   logic                  full_s;
   logic                  empty_s;
   fifo_status_t          status_s;
   logic                  rd_accept_s;
   logic                  wr_accept_s;
   logic                  wr_ack_r;
   logic                  overflow_r;
   logic                  underflow_r;
   logic                  sticky_r;
   logic                  valid_r;
   logic                  byp_r;
   logic [FIFO_WIDTH-1:0] byp_data_r;
   logic [FIFO_WIDTH-1:0] ram_q_s;
   logic                  ram_re_s;
   logic [PW-1:0]         ram_raddr_s;

   // Depth need not be a power of two, so wrap is an explicit compare.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(FIFO_DEPTH - 1)) begin
         return {PW{1'b0}};
      end else begin
         return p + PW'(1);
      end
   endfunction

   // status flags decoded from occupancy
   always_comb begin
      full_s                = (count_r == CW'(FIFO_DEPTH));
      empty_s               = (count_r == {CW{1'b0}});
      status_s              = '0;
      status_s.full         = full_s;
      status_s.empty        = empty_s;
      status_s.almostfull   = (count_r >= CW'(AF_LEVEL)) && !full_s;
      status_s.almostempty  = (count_r <= CW'(AE_LEVEL)) && !empty_s;
      status_s.count        = STATUS_CNT_W'(count_r);
   end

   // handshake acceptance and storage addressing
   always_comb begin
      rd_accept_s = rd_en && !empty_s;
      wr_accept_s = wr_en && (!full_s || rd_accept_s);
      if (rd_accept_s) begin
         rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
      end else begin
         rd_ptr_nxt_s = rd_ptr_r;
      end
      // FWFT keeps the RAM output tracking the head the pointer will point at
      if (FWFT != 0) begin
         ram_re_s    = 1'b1;
         ram_raddr_s = rd_ptr_nxt_s;
      end else begin
         ram_re_s    = rd_accept_s;
         ram_raddr_s = rd_ptr_r;
      end
   end

   // pointers, occupancy, handshake status and FWFT write bypass
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r    <= {PW{1'b0}};
         rd_ptr_r    <= {PW{1'b0}};
         count_r     <= {CW{1'b0}};
         wr_ack_r    <= 1'b0;
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
         sticky_r    <= 1'b0;
         valid_r     <= 1'b0;
         byp_r       <= 1'b0;
         byp_data_r  <= {FIFO_WIDTH{1'b0}};
      end else begin
         if (wr_accept_s) begin
            wr_ptr_r <= ptr_inc(wr_ptr_r);
         end
         rd_ptr_r <= rd_ptr_nxt_s;
         case ({wr_accept_s, rd_accept_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
         wr_ack_r    <= wr_accept_s;
         overflow_r  <= wr_en && !wr_accept_s;
         underflow_r <= rd_en && empty_s;
         if ((wr_en && !wr_accept_s) || (rd_en && empty_s)) begin
            sticky_r <= 1'b1;
         end else if (clr_err) begin
            sticky_r <= 1'b0;
         end
         valid_r    <= rd_accept_s;
         // a write landing on the next head slot is not yet visible at the RAM output
         byp_r      <= wr_accept_s && (wr_ptr_r == rd_ptr_nxt_s);
         byp_data_r <= data_in;
      end
   end

   fifo_ram #(
      .WIDTH (FIFO_WIDTH),
      .DEPTH (FIFO_DEPTH),
      .AW    (PW)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_accept_s),
      .waddr (wr_ptr_r),
      .wdata (data_in),
      .re    (ram_re_s),
      .raddr (ram_raddr_s),
      .rdata (ram_q_s)
   );

   // read data / valid selection per read mode
   always_comb begin
      if (FWFT != 0) begin
         valid = !empty_s;
         if (byp_r) begin
            data_out = byp_data_r;
         end else begin
            data_out = ram_q_s;
         end
      end else begin
         valid    = valid_r;
         data_out = ram_q_s;
      end
   end

   assign full        = status_s.full;
   assign empty       = status_s.empty;
   assign almostfull  = status_s.almostfull;
   assign almostempty = status_s.almostempty;
   assign count       = (status_s.count > STATUS_CNT_W'(FIFO_DEPTH)) ? CW'(FIFO_DEPTH)
                                                                     : status_s.count[CW-1:0];
   assign wr_ack      = wr_ack_r;
   assign overflow    = overflow_r;
   assign underflow   = underflow_r;
   assign sticky_err  = sticky_r;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Three FIFO configurations checked every cycle against a list-based model.
module tb_sync_fifo_prog;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]       rst, wr_en, rd_en, clr_err;
   logic [2:0][15:0] din;
   logic [2:0][15:0] dout;
   logic [2:0]       valid, wr_ack, ovf, udf, full, empty, af, ae, sticky;
   logic [3:0]       cnt0, cnt1;
   logic [2:0]       cnt2;

   int p_d  [3] = '{8, 8, 6};
   int p_f  [3] = '{0, 1, 0};
   int p_af [3] = '{7, 7, 4};
   int p_ae [3] = '{1, 1, 2};

   logic [15:0] m_data [3][8];
   int          m_cnt  [3];
   logic [15:0] m_dout [3];
   bit          m_valid[3], m_ack[3], m_ovf[3], m_udf[3], m_sticky[3];

   int n_pass = 0;
   int n_total = 0;

   sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(0), .AF_LEVEL(7), .AE_LEVEL(1)) u0 (
      .clk(clk), .rst(rst[0]), .data_in(din[0]), .wr_en(wr_en[0]), .rd_en(rd_en[0]),
      .clr_err(clr_err[0]), .data_out(dout[0]), .valid(valid[0]), .wr_ack(wr_ack[0]),
      .overflow(ovf[0]), .underflow(udf[0]), .full(full[0]), .empty(empty[0]),
      .almostfull(af[0]), .almostempty(ae[0]), .count(cnt0), .sticky_err(sticky[0]));

   sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1), .AF_LEVEL(7), .AE_LEVEL(1)) u1 (
      .clk(clk), .rst(rst[1]), .data_in(din[1]), .wr_en(wr_en[1]), .rd_en(rd_en[1]),
      .clr_err(clr_err[1]), .data_out(dout[1]), .valid(valid[1]), .wr_ack(wr_ack[1]),
      .overflow(ovf[1]), .underflow(udf[1]), .full(full[1]), .empty(empty[1]),
      .almostfull(af[1]), .almostempty(ae[1]), .count(cnt1), .sticky_err(sticky[1]));

   sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(6), .FWFT(0), .AF_LEVEL(4), .AE_LEVEL(2)) u2 (
      .clk(clk), .rst(rst[2]), .data_in(din[2]), .wr_en(wr_en[2]), .rd_en(rd_en[2]),
      .clr_err(clr_err[2]), .data_out(dout[2]), .valid(valid[2]), .wr_ack(wr_ack[2]),
      .overflow(ovf[2]), .underflow(udf[2]), .full(full[2]), .empty(empty[2]),
      .almostfull(af[2]), .almostempty(ae[2]), .count(cnt2), .sticky_err(sticky[2]));

   task automatic check(input string name, input int i, input logic [31:0] act,
                        input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s inst%0d: actual %0h required %0h (t=%0t)", name, i, act, exp, $time);
      end
   endtask

   // Queue semantics: reads take from the front, writes append at the back.
   task automatic model_step(input int i);
      bit e, f, rok, wok;
      if (rst[i]) begin
         m_cnt[i] = 0; m_dout[i] = 16'h0; m_valid[i] = 0;
         m_ack[i] = 0; m_ovf[i] = 0; m_udf[i] = 0; m_sticky[i] = 0;
      end else begin
         e   = (m_cnt[i] == 0);
         f   = (m_cnt[i] == p_d[i]);
         rok = rd_en[i] && !e;
         wok = wr_en[i] && (!f || rok);
         m_ack[i] = wok;
         m_ovf[i] = wr_en[i] && !wok;
         m_udf[i] = rd_en[i] && e;
         if (m_ovf[i] || m_udf[i]) m_sticky[i] = 1;
         else if (clr_err[i]) m_sticky[i] = 0;
         m_valid[i] = rok;
         if (rok) begin
            m_dout[i] = m_data[i][0];
            for (int k = 0; k < 7; k++) m_data[i][k] = m_data[i][k+1];
            m_cnt[i]--;
         end
         if (wok) begin
            m_data[i][m_cnt[i]] = din[i];
            m_cnt[i]++;
         end
      end
   endtask

   task automatic compare_all();
      logic [31:0] c;
      for (int i = 0; i < 3; i++) begin
         c = (i == 0) ? 32'(cnt0) : (i == 1) ? 32'(cnt1) : 32'(cnt2);
         check("count", i, c, m_cnt[i]);
         check("full", i, full[i], m_cnt[i] == p_d[i]);
         check("empty", i, empty[i], m_cnt[i] == 0);
         check("almostfull", i, af[i], (m_cnt[i] >= p_af[i]) && (m_cnt[i] != p_d[i]));
         check("almostempty", i, ae[i], (m_cnt[i] <= p_ae[i]) && (m_cnt[i] != 0));
         check("wr_ack", i, wr_ack[i], m_ack[i]);
         check("overflow", i, ovf[i], m_ovf[i]);
         check("underflow", i, udf[i], m_udf[i]);
         check("sticky_err", i, sticky[i], m_sticky[i]);
         if (p_f[i] != 0) begin
            check("valid", i, valid[i], m_cnt[i] != 0);
            if (m_cnt[i] != 0) check("data_out", i, dout[i], m_data[i][0]);
         end else begin
            check("valid", i, valid[i], m_valid[i]);
            check("data_out", i, dout[i], m_dout[i]);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      for (int i = 0; i < 3; i++) model_step(i);
      @(negedge clk);
      compare_all();
   endtask

   task automatic drive(input int i, input bit r, input bit w, input bit rd,
                        input logic [15:0] d, input bit c);
      rst = '0; wr_en = '0; rd_en = '0; clr_err = '0; din = '0;
      rst[i] = r; wr_en[i] = w; rd_en[i] = rd; din[i] = d; clr_err[i] = c;
      tick();
   endtask

   initial begin
      int pw;
      rst = 3'b111; wr_en = '0; rd_en = '0; clr_err = '0; din = '0;
      tick();
      tick();
      check("rst_empty", 0, empty, 3'b111);
      check("rst_count0", 0, cnt0, 4'd0);
      check("rst_dout_fwft", 1, dout[1], 16'h0);

      // in-order write/read on depth 8
      for (int k = 1; k <= 8; k++) begin
         drive(0, 0, 1, 0, 16'(k), 0);
         if (k == 7) check("t1_af_at7", 0, af[0], 1'b1);
      end
      check("t1_full", 0, full[0], 1'b1);
      for (int k = 1; k <= 8; k++) begin
         drive(0, 0, 0, 1, 16'h0, 0);
         check("t1_rd_data", 0, dout[0], 16'(k));
      end
      check("t1_empty", 0, empty[0], 1'b1);

      // overflow and sticky clear
      for (int k = 1; k <= 8; k++) drive(0, 0, 1, 0, 16'h0010 + 16'(k), 0);
      drive(0, 0, 1, 0, 16'hDEAD, 0);
      check("t2_overflow", 0, ovf[0], 1'b1);
      check("t2_wr_ack", 0, wr_ack[0], 1'b0);
      check("t2_count", 0, cnt0, 4'd8);
      check("t2_sticky", 0, sticky[0], 1'b1);
      drive(0, 0, 0, 0, 16'h0, 1);
      check("t2_sticky_clr", 0, sticky[0], 1'b0);

      // full: simultaneous read and write
      drive(0, 0, 1, 1, 16'hBEEF, 0);
      check("t4_count", 0, cnt0, 4'd8);
      check("t4_oldest", 0, dout[0], 16'h0011);
      for (int k = 0; k < 8; k++) drive(0, 0, 0, 1, 16'h0, 0);
      check("t4_last", 0, dout[0], 16'hBEEF);

      // empty: simultaneous read and write
      drive(0, 0, 1, 1, 16'h0055, 0);
      check("t3_underflow", 0, udf[0], 1'b1);
      check("t3_wr_ack", 0, wr_ack[0], 1'b1);
      check("t3_count", 0, cnt0, 4'd1);
      check("t3_valid", 0, valid[0], 1'b0);
      drive(0, 0, 0, 1, 16'h0, 0);

      // FWFT head visible without a read
      drive(1, 0, 1, 0, 16'h00AA, 0);
      check("t5_valid", 1, valid[1], 1'b1);
      check("t5_data", 1, dout[1], 16'h00AA);
      drive(1, 0, 0, 1, 16'h0, 0);
      check("t5_valid_pop", 1, valid[1], 1'b0);
      check("t5_empty", 1, empty[1], 1'b1);

      // depth 6 with wrap and mid-operation reset
      drive(2, 0, 1, 0, 16'h0201, 0);
      drive(2, 0, 1, 0, 16'h0202, 0);
      check("t6_ae_at2", 2, ae[2], 1'b1);
      drive(2, 0, 1, 0, 16'h0203, 0);
      check("t6_flags_at3", 2, {af[2], ae[2]}, 2'b00);
      drive(2, 0, 0, 1, 16'h0, 0);
      drive(2, 0, 0, 1, 16'h0, 0);
      for (int k = 4; k <= 8; k++) begin
         drive(2, 0, 1, 0, 16'h0200 + 16'(k), 0);
         if (k == 6) check("t6_af_at4", 2, af[2], 1'b1);
      end
      check("t6_full_at6", 2, {full[2], af[2]}, 2'b10);
      for (int k = 0; k < 3; k++) drive(2, 0, 0, 1, 16'h0, 0);
      check("t6_wrap_data", 2, dout[2], 16'h0205);
      drive(2, 0, 1, 1, 16'h0209, 0);
      drive(2, 0, 1, 1, 16'h020A, 0);
      drive(2, 0, 1, 0, 16'h020B, 0);
      drive(2, 0, 0, 1, 16'h0, 0);
      drive(2, 0, 1, 0, 16'h020C, 0);
      drive(2, 0, 0, 1, 16'h0, 0);
      check("t6_count3", 2, cnt2, 3'd3);
      drive(2, 1, 1, 1, 16'h0, 0);
      check("t6_rst_count", 2, cnt2, 3'd0);

      // randomized traffic on all three configurations
      for (int cyc = 0; cyc < 4000; cyc++) begin
         pw = (((cyc / 150) % 2) == 0) ? 70 : 30;
         for (int i = 0; i < 3; i++) begin
            rst[i]     = ($urandom_range(0, 249) == 0);
            wr_en[i]   = ($urandom_range(0, 99) < pw);
            rd_en[i]   = ($urandom_range(0, 99) < (100 - pw));
            clr_err[i] = ($urandom_range(0, 15) == 0);
            din[i]     = 16'($urandom);
         end
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
